cam_cfg_seq: RTL and testbench
==============================

CAM_CFG_SEQ -- requirements
Module: cam_cfg_seq

Interface
REQ-001 The block SHALL expose the parameter ADDR_W, default 8, as the camera register address width.
REQ-002 The block SHALL expose the parameter DATA_W, default 8, as the camera register data width.
REQ-003 The block SHALL expose the parameter IDX_W, default 7, as the width of the entry index within one profile (2^IDX_W entries per profile).
REQ-004 The block SHALL expose the parameter PROF_W, default 1, as the width of the profile select (2^PROF_W profiles).
REQ-005 The block SHALL expose the parameter DELAY_TICK, default 24000, as clock cycles per delay unit (1 ms at 24 MHz).
REQ-006 The block SHALL expose the parameter MAX_RETRY, default 3, as the retries per entry when CAM_CFG_RETRY_EN is defined.
REQ-007 i_Clk  in  1  the single clock; one clock; all logic on its rising edge.
REQ-008 i_Rst  in  1  reset; synchronous and active-high.
REQ-009 i_Start  in  1  one-cycle pulse that starts a sequence; ignored while o_Busy=1.
REQ-010 i_Profile  in  PROF_W  profile select, sampled on the accepted i_Start.
REQ-011 o_Rom_Addr  out  PROF_W+IDX_W  table read address {profile, index}.
REQ-012 i_Rom_Data  in  ADDR_W+DATA_W  entry {reg_addr, reg_data}, valid one cycle after o_Rom_Addr.
REQ-013 o_Wr_Valid, o_Wr_Addr[ADDR_W], o_Wr_Data[DATA_W]  out  write request to the SCCB master.
REQ-014 i_Wr_Ready  in  1  the master accepts the request in a cycle with o_Wr_Valid=1 and i_Wr_Ready=1.
REQ-015 i_Wr_Done, i_Wr_Nack  in  1  completion pulse and its NACK flag (i_Wr_Nack qualified by i_Wr_Done).
REQ-016 o_Busy, o_Done, o_Err  out  1  sequence active; one-cycle end pulse; sticky error flag.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, DECODE, WRITE, WAIT_DONE, DELAY and FINISH.
REQ-018 In IDLE, an i_Start pulse SHALL latch i_Profile, clear the index and o_Err, set o_Busy and move to FETCH.
REQ-019 FETCH SHALL drive o_Rom_Addr={profile,index} for one cycle and then move to DECODE, where i_Rom_Data is registered.
REQ-020 The all-ones entry SHALL be the end marker: move to FINISH with no write issued.
REQ-021 An entry with an all-ones address field and any other data value D SHALL be a delay: stay in DELAY for D*DELAY_TICK cycles; D=0 SHALL proceed on the next cycle.
REQ-022 Any other entry SHALL enter WRITE with o_Wr_Valid=1 and o_Wr_Addr/o_Wr_Data held stable until the handshake completes.
REQ-023 After the handshake, o_Wr_Valid SHALL drop and the FSM SHALL enter WAIT_DONE until i_Wr_Done=1.
REQ-024 i_Wr_Done with i_Wr_Nack=0 SHALL advance the index and return to FETCH.
REQ-025 After the delay ends, the index SHALL advance and the FSM SHALL return to FETCH.
REQ-026 If index 2^IDX_W-1 completes without an end marker, the sequence SHALL finish; the index SHALL NOT wrap.
REQ-027 FINISH SHALL pulse o_Done for exactly one cycle, clear o_Busy and return to IDLE; a new i_Start SHALL be accepted from the following cycle.
REQ-028 i_Wr_Done, i_Wr_Ready and i_Wr_Nack outside their qualifying states SHALL be ignored.
REQ-029 i_Start while o_Busy=1 SHALL be ignored, including in FINISH.
REQ-030 The delay counter SHALL be wide enough for (2^DATA_W-2)*DELAY_TICK cycles without overflow.

Reset
REQ-031 While i_Rst=1 at a clock edge: FSM IDLE, index 0, all counters 0, and all outputs 0 (o_Rom_Addr, o_Wr_*, o_Busy, o_Done, o_Err).
REQ-032 Reset asserted mid-sequence SHALL abort the sequence with no further o_Wr_Valid and no o_Done pulse.

Configuration
REQ-033 With CAM_CFG_RETRY_EN defined, a NACK SHALL re-enter WRITE with the same entry, up to MAX_RETRY times; the retry count clears on each new entry.
REQ-034 With CAM_CFG_RETRY_EN defined, a NACK after MAX_RETRY retries SHALL set o_Err and go to FINISH.
REQ-035 Without CAM_CFG_RETRY_EN, the first NACK SHALL set o_Err and go to FINISH, and no retry counter SHALL be synthesised.
REQ-036 o_Err SHALL remain set until reset or the next accepted i_Start.

Verification
REQ-037 Profile 0 table {12_80, FF_0A, 12_04, FF_FF}, DELAY_TICK=4, i_Wr_Ready tied 1 -> writes 12/80 then 12/04 with exactly 40 DELAY cycles between them, then one o_Done pulse, o_Err=0.
REQ-038 i_Profile=1 -> first o_Rom_Addr=0x80, then 0x81, and so on.
REQ-039 i_Wr_Ready held 0 for 5 cycles -> o_Wr_Valid/o_Wr_Addr/o_Wr_Data stable for all 5 cycles; exactly one transfer occurs.
REQ-040 NACK on entry 1, CAM_CFG_RETRY_EN defined -> entry re-issued 3 times, o_Err=1 after the 4th NACK; without the macro -> o_Err=1 after the 1st NACK, o_Done pulses once.
REQ-041 Table with no end marker -> 128 entries processed, then o_Done; i_Start mid-sequence -> ignored.
REQ-042 i_Rst=1 during DELAY -> next cycle o_Busy=0 and no o_Done pulse; a new i_Start restarts from index 0.

Source files
------------

// File: rtl/cam_cfg_seq.sv
// Camera register configuration sequencer: walks a {reg_addr, reg_data} table and issues SCCB writes.
// Optional build macro CAM_CFG_RETRY_EN adds per-entry NACK retries (up to MAX_RETRY).
module cam_cfg_seq #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int IDX_W      = 7,
  parameter int PROF_W     = 1,
  parameter int DELAY_TICK = 24000,
  parameter int MAX_RETRY  = 3
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic                      i_Start,
  input  logic [PROF_W-1:0]         i_Profile,
  output logic [PROF_W+IDX_W-1:0]   o_Rom_Addr,
  input  logic [ADDR_W+DATA_W-1:0]  i_Rom_Data,
  output logic                      o_Wr_Valid,
  output logic [ADDR_W-1:0]         o_Wr_Addr,
  output logic [DATA_W-1:0]         o_Wr_Data,
  input  logic                      i_Wr_Ready,
  input  logic                      i_Wr_Done,
  input  logic                      i_Wr_Nack,
  output logic                      o_Busy,
  output logic                      o_Done,
  output logic                      o_Err,
  output logic [2:0]                o_Dbg_State
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] DECODE    = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] DELAY     = 3'd5;
  localparam logic [2:0] FINISH    = 3'd6;

  // Longest delay entry is data 2^DATA_W-2 (all-ones data is the end marker).
  localparam longint MAX_DELAY = ((longint'(1) << DATA_W) - 2) * longint'(DELAY_TICK);
  localparam int     CNT_W     = (MAX_DELAY > 1) ? $clog2(MAX_DELAY + 1) : 1;

  if (MAX_RETRY < 0) begin : g_bad_retry
    $error("MAX_RETRY must be non-negative");
  end

  logic [2:0]        state;
  logic [PROF_W-1:0] prof_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  dly_cnt;

  logic [ADDR_W-1:0] ent_addr;
  logic [DATA_W-1:0] ent_data;
  logic              ent_is_end;
  logic              ent_is_delay;
  logic              idx_last;
  logic              retry_ok;

  assign ent_addr     = i_Rom_Data[ADDR_W+DATA_W-1 -: ADDR_W];
  assign ent_data     = i_Rom_Data[DATA_W-1:0];
  assign ent_is_end   = &i_Rom_Data;
  assign ent_is_delay = &ent_addr;
  assign idx_last     = &idx_q;

`ifdef CAM_CFG_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [RETRY_W-1:0] retry_cnt;

  assign retry_ok = (retry_cnt < RETRY_W'(MAX_RETRY));

  // Retry count belongs to the current entry; it clears whenever a new entry is decoded.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      retry_cnt <= '0;
    end else if (state == DECODE) begin
      retry_cnt <= '0;
    end else if (state == WAIT_DONE && i_Wr_Done && i_Wr_Nack && retry_ok) begin
      retry_cnt <= retry_cnt + RETRY_W'(1);
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  // Write handshake: o_Wr_Valid rises in WRITE with o_Wr_Addr/o_Wr_Data frozen, and a
  // transfer happens on the first edge where o_Wr_Valid && i_Wr_Ready; valid then drops.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= IDLE;
      prof_q     <= '0;
      idx_q      <= '0;
      dly_cnt    <= '0;
      o_Wr_Valid <= 1'b0;
      o_Wr_Addr  <= '0;
      o_Wr_Data  <= '0;
      o_Err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Start) begin
            prof_q <= i_Profile;
            idx_q  <= '0;
            o_Err  <= 1'b0;
            state  <= FETCH;
          end
        end

        FETCH: begin
          state <= DECODE;
        end

        DECODE: begin
          if (ent_is_end) begin
            state <= FINISH;
          end else if (ent_is_delay) begin
            dly_cnt <= CNT_W'(ent_data) * CNT_W'(DELAY_TICK);
            state   <= DELAY;
          end else begin
            o_Wr_Addr  <= ent_addr;
            o_Wr_Data  <= ent_data;
            o_Wr_Valid <= 1'b1;
            state      <= WRITE;
          end
        end

        WRITE: begin
          if (i_Wr_Ready) begin
            o_Wr_Valid <= 1'b0;
            state      <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (i_Wr_Done) begin
            if (i_Wr_Nack) begin
              if (retry_ok) begin
                o_Wr_Valid <= 1'b1;
                state      <= WRITE;
              end else begin
                o_Err <= 1'b1;
                state <= FINISH;
              end
            end else if (idx_last) begin
              state <= FINISH;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              state <= FETCH;
            end
          end
        end

        DELAY: begin
          // A count of 0 or 1 ends the delay on this cycle.
          if (dly_cnt <= CNT_W'(1)) begin
            dly_cnt <= '0;
            if (idx_last) begin
              state <= FINISH;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              state <= FETCH;
            end
          end else begin
            dly_cnt <= dly_cnt - CNT_W'(1);
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_Rom_Addr  = (state == FETCH) ? {prof_q, idx_q} : '0;
  assign o_Busy      = (state != IDLE);
  assign o_Done      = (state == FINISH);
  assign o_Dbg_State = state;

endmodule

// File: tb/tb_cam_cfg_seq.sv
// Directed bench for cam_cfg_seq: ROM and SCCB-slave models, write/done scoreboard, final report.
`timescale 1ns/1ps
module tb_cam_cfg_seq;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int IDX_W      = 7;
  localparam int PROF_W     = 1;
  localparam int DELAY_TICK = 4;
  localparam int MAX_RETRY  = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DELAY = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                     i_Start;
  logic [PROF_W-1:0]        i_Profile;
  logic [PROF_W+IDX_W-1:0]  o_Rom_Addr;
  logic [ADDR_W+DATA_W-1:0] i_Rom_Data;
  logic                     o_Wr_Valid;
  logic [ADDR_W-1:0]        o_Wr_Addr;
  logic [DATA_W-1:0]        o_Wr_Data;
  logic                     i_Wr_Ready;
  logic                     i_Wr_Done;
  logic                     i_Wr_Nack;
  logic                     o_Busy;
  logic                     o_Done;
  logic                     o_Err;
  logic [2:0]               dbg_state;

  cam_cfg_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .PROF_W(PROF_W),
    .DELAY_TICK(DELAY_TICK), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(i_Start), .i_Profile(i_Profile),
    .o_Rom_Addr(o_Rom_Addr), .i_Rom_Data(i_Rom_Data),
    .o_Wr_Valid(o_Wr_Valid), .o_Wr_Addr(o_Wr_Addr), .o_Wr_Data(o_Wr_Data),
    .i_Wr_Ready(i_Wr_Ready), .i_Wr_Done(i_Wr_Done), .i_Wr_Nack(i_Wr_Nack),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Err(o_Err), .o_Dbg_State(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [15:0] exp_q[$];
  logic        exp_done_q[$];
  logic [7:0]  fetch_q[$];
  int          dly_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ROM model: data valid one cycle after address ----------------
  logic [15:0] rom [0:255];
  logic [7:0]  rom_a = '0;
  initial begin
    i_Rom_Data = '0;
    forever begin
      @(negedge clk);
      i_Rom_Data = rom[rom_a];
      rom_a      = o_Rom_Addr;
    end
  end

  // ---------------- SCCB slave model ----------------
  int         stall_left = 0;
  int         nack_left  = 0;
  logic [7:0] nack_addr  = 8'h00;
  bit         spurious   = 1'b0;
  int         done_cd    = 0;
  logic       resp_nack  = 1'b0;

  initial begin
    i_Wr_Ready = 1'b0;
    i_Wr_Done  = 1'b0;
    i_Wr_Nack  = 1'b0;
    forever begin
      @(negedge clk);
      i_Wr_Done = 1'b0;
      i_Wr_Nack = 1'b0;
      if (rst) begin
        done_cd    = 0;
        i_Wr_Ready = 1'b0;
      end else begin
        if (done_cd > 0) begin
          done_cd--;
          if (done_cd == 0) begin
            i_Wr_Done = 1'b1;
            i_Wr_Nack = resp_nack;
          end
        end else if (spurious && dbg_state == S_DELAY) begin
          i_Wr_Done = 1'b1;
          i_Wr_Nack = 1'b1;
        end
        if (o_Wr_Valid) begin
          if (stall_left > 0) begin
            i_Wr_Ready = 1'b0;
            stall_left--;
          end else begin
            i_Wr_Ready = 1'b1;
            done_cd    = 3;
            resp_nack  = (o_Wr_Addr == nack_addr) && (nack_left > 0);
            if (resp_nack) nack_left--;
          end
        end else begin
          i_Wr_Ready = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [15:0] e;
    logic        ed;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (o_Wr_Valid) begin
          if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'({o_Wr_Addr, o_Wr_Data}), 32'hFFFF_FFFF);
          end else if (i_Wr_Ready) begin
            e = exp_q.pop_front();
            check("wr_xfer", 32'({o_Wr_Addr, o_Wr_Data}), 32'(e));
          end else begin
            check("wr_stall_hold", 32'({o_Wr_Addr, o_Wr_Data}), 32'(exp_q[0]));
          end
        end
        if (o_Done) begin
          if (exp_done_q.size() == 0) begin
            check("done_unexpected", 32'(o_Done), 32'(0));
          end else begin
            ed = exp_done_q.pop_front();
            check("done_err", 32'(o_Err), 32'(ed));
          end
        end
        if (dbg_state == S_FETCH) fetch_q.push_back(o_Rom_Addr);
        if (dbg_state == S_DELAY) dly_cycles++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_rom_ff();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic start_seq(input logic [PROF_W-1:0] p);
    @(negedge clk);
    i_Start   = 1'b1;
    i_Profile = p;
    @(negedge clk);
    i_Start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name, input bit poke_finish);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (o_Done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s: o_Done not seen within %0d cycles", name, budget);
    end else if (poke_finish) begin
      i_Start   = 1'b1;
      i_Profile = 1'b0;
    end
    @(negedge clk);
    #2;
    i_Start = 1'b0;
    check({name, "_done_one_cycle"}, 32'(o_Done), 32'(0));
    check({name, "_busy_clear"}, 32'(o_Busy), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    i_Start   = 1'b0;
    i_Profile = '0;
    fill_rom_ff();
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy",     32'(o_Busy),     32'(0));
    check("rst_done",     32'(o_Done),     32'(0));
    check("rst_err",      32'(o_Err),      32'(0));
    check("rst_wr_valid", 32'(o_Wr_Valid), 32'(0));
    check("rst_wr_addr",  32'(o_Wr_Addr),  32'(0));
    check("rst_wr_data",  32'(o_Wr_Data),  32'(0));
    check("rst_rom_addr", 32'(o_Rom_Addr), 32'(0));
    check("rst_state",    32'(dbg_state),  32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic table with a 10-unit delay; stray done/nack pulses while delaying.
    rom[0] = 16'h1280; rom[1] = 16'hFF0A; rom[2] = 16'h1204; rom[3] = 16'hFFFF;
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1204); exp_done_q.push_back(1'b0);
    dly_cycles = 0; fetch_q.delete(); spurious = 1'b1;
    start_seq(1'b0);
    wait_done(300, "basic", 1'b0);
    spurious = 1'b0;
    check("basic_delay_cycles", 32'(dly_cycles), 32'd40);
    check("basic_err", 32'(o_Err), 32'(0));
    check("basic_fetch_cnt", 32'(fetch_q.size()), 32'd4);

    // Profile 1 addresses, zero-length delay, start poked during FINISH.
    rom[8'h80] = 16'h3456; rom[8'h81] = 16'hFF00; rom[8'h82] = 16'h3501; rom[8'h83] = 16'hFFFF;
    exp_q.push_back(16'h3456); exp_q.push_back(16'h3501); exp_done_q.push_back(1'b0);
    fetch_q.delete();
    start_seq(1'b1);
    wait_done(300, "prof1", 1'b1);
    check("prof1_fetch_cnt", 32'(fetch_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < fetch_q.size(); i++)
      check("prof1_fetch_addr", 32'(fetch_q[i]), 32'h80 + 32'(i));
    repeat (6) @(negedge clk);
    #2;
    check("finish_start_ignored", 32'(o_Busy), 32'(0));

    // Back-pressure on the first write, plus a start pulse mid-sequence.
    exp_q.push_back(16'h1280); exp_q.push_back(16'h1204); exp_done_q.push_back(1'b0);
    stall_left = 5;
    start_seq(1'b0);
    repeat (15) @(negedge clk);
    i_Start = 1'b1; i_Profile = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    wait_done(300, "stall", 1'b0);
    check("stall_consumed", 32'(stall_left), 32'(0));

    // NACK on entry 1.
    fill_rom_ff();
    rom[0] = 16'h2001; rom[1] = 16'h2102; rom[2] = 16'h2203; rom[3] = 16'hFFFF;
    exp_q.push_back(16'h2001);
    exp_q.push_back(16'h2102);
`ifdef CAM_CFG_RETRY_EN
    nack_left = 4;
    for (int i = 0; i < MAX_RETRY; i++) exp_q.push_back(16'h2102);
`else
    nack_left = 1;
`endif
    nack_addr = 8'h21;
    exp_done_q.push_back(1'b1);
    start_seq(1'b0);
    wait_done(300, "nack", 1'b0);
    check("nack_consumed", 32'(nack_left), 32'(0));
    repeat (4) @(negedge clk);
    #2;
    check("err_sticky", 32'(o_Err), 32'(1));

    // No end marker: all 128 entries of profile 1, a stray start mid-run.
    for (int i = 0; i < 128; i++) begin
      rom[128 + i] = {8'(i), 8'(i * 3 + 1)};
      exp_q.push_back({8'(i), 8'(i * 3 + 1)});
    end
    exp_done_q.push_back(1'b0);
    fetch_q.delete();
    start_seq(1'b1);
    #2;
    check("err_cleared_on_start", 32'(o_Err), 32'(0));
    repeat (100) @(negedge clk);
    i_Start = 1'b1; i_Profile = 1'b0;
    @(negedge clk);
    i_Start = 1'b0;
    wait_done(3000, "full", 1'b0);
    check("full_fetch_cnt", 32'(fetch_q.size()), 32'd128);
    if (fetch_q.size() > 0)
      check("full_last_fetch", 32'(fetch_q[fetch_q.size() - 1]), 32'hFF);

    // Reset during a delay, then restart from index 0.
    fill_rom_ff();
    rom[0] = 16'hFF05; rom[1] = 16'h5001;
    start_seq(1'b0);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        #2;
        if (dbg_state == S_DELAY) begin
          hit = 1'b1;
          break;
        end
      end
      check("reach_delay", 32'(hit), 32'(1));
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("rst_mid_busy",  32'(o_Busy),     32'(0));
    check("rst_mid_done",  32'(o_Done),     32'(0));
    check("rst_mid_valid", 32'(o_Wr_Valid), 32'(0));
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    check("after_rst_idle", 32'(dbg_state), 32'(S_IDLE));
    rom[0] = 16'h4011; rom[1] = 16'hFFFF;
    exp_q.push_back(16'h4011); exp_done_q.push_back(1'b0);
    fetch_q.delete();
    start_seq(1'b0);
    wait_done(300, "restart", 1'b0);
    if (fetch_q.size() > 0)
      check("restart_first_fetch", 32'(fetch_q[0]), 32'h00);
    else
      check("restart_fetch_seen", 32'(fetch_q.size()), 32'd2);

    repeat (5) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'(0));
    check("exp_done_q_empty", 32'(exp_done_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
